// File: rtl/carregador_matriz_pkg.sv
// Shared definitions for the matrix loader: widths, size encodings,
// FSM state encoding and size-decoding helpers.
package pkg_matriz;

   localparam int unsigned ELEM_W   = 8;
   localparam int unsigned MAX_ELEM = 25;
   localparam int unsigned IDX_W    = 5;
   localparam int unsigned DIM_W    = 3;

   typedef enum logic [1:0] {
      SIZE_2X2 = 2'b00,
      SIZE_3X3 = 2'b01,
      SIZE_4X4 = 2'b10,
      SIZE_5X5 = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Number of active elements for a given size code
   function automatic logic [IDX_W-1:0] active_elements(input logic [1:0] size);
      case (size_e'(size))
         SIZE_2X2: return IDX_W'(4);
         SIZE_3X3: return IDX_W'(9);
         SIZE_4X4: return IDX_W'(16);
         SIZE_5X5: return IDX_W'(25);
         default:  return IDX_W'(4);
      endcase
   endfunction

   // Matrix dimension N for a given size code
   function automatic logic [DIM_W-1:0] dim(input logic [1:0] size);
      case (size_e'(size))
         SIZE_2X2: return DIM_W'(2);
         SIZE_3X3: return DIM_W'(3);
         SIZE_4X4: return DIM_W'(4);
         SIZE_5X5: return DIM_W'(5);
         default:  return DIM_W'(2);
      endcase
   endfunction

endpackage

// File: rtl/carregador_matriz_contador_indice.sv
// Element/row/col counters for the matrix loader. Produces the packed slot
// index of the current element and a flag marking the final active element.
// Optional macro: CARREGADOR_COL_MAJOR_EN (stream arrives column-major; the
// slot index is still row*N + col so the packed layout is unchanged).
module contador_indice
   import pkg_matriz::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             advance,
   input  logic [1:0]       size,
   output logic [IDX_W-1:0] index,
   output logic             last
);

   logic [IDX_W-1:0] k;
   logic [IDX_W-1:0] active;

   assign active = active_elements(size);
   assign last   = (k == active - IDX_W'(1));

   // Element counter: number of elements accepted so far in this load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k <= '0;
      end else if (clear) begin
         k <= '0;
      end else if (advance) begin
         k <= k + IDX_W'(1);
      end
   end

`ifdef CARREGADOR_COL_MAJOR_EN
   logic [DIM_W-1:0] n;
   logic [DIM_W-1:0] row;
   logic [DIM_W-1:0] col;

   assign n = dim(size);

   // Row advances first; wrapping the row at N-1 moves to the next column
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (row == n - DIM_W'(1)) begin
            row <= '0;
            col <= col + DIM_W'(1);
         end else begin
            row <= row + DIM_W'(1);
         end
      end
   end

   assign index = IDX_W'(row) * IDX_W'(n) + IDX_W'(col);
`else
   // Row-major stream: row*N + col equals the element count, so the
   // row/col pair collapses onto k
   assign index = k;
`endif

endmodule

// File: rtl/carregador_matriz.sv
// Matrix loader: latches scalar and size on start, packs a valid/ready stream
// of signed 8-bit elements into a 200-bit matrix register and pulses done.
// Optional macro: CARREGADOR_COL_MAJOR_EN (handled in contador_indice).
module carregador_matriz
   import pkg_matriz::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [1:0]                 matrix_size,
   input  logic [ELEM_W-1:0]          num_inteiro_in,
   input  logic [ELEM_W-1:0]          data_in,
   input  logic                       data_valid,
   output logic                       data_ready,
   output logic [ELEM_W*MAX_ELEM-1:0] matriz_A,
   output logic [ELEM_W-1:0]          num_inteiro,
   output logic [1:0]                 matrix_size_out,
   output logic                       busy,
   output logic                       matriz_valid,
   output logic                       done
);

   state_e           state;
   state_e           next_state;
   logic             start_accept;
   logic             xfer;
   logic             last;
   logic [IDX_W-1:0] index;

   contador_indice u_contador (
      .clk     (clk),
      .reset   (reset),
      .clear   (start_accept),
      .advance (xfer),
      .size    (matrix_size_out),
      .index   (index),
      .last    (last)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode plus state-decoded handshake and status outputs
   always_comb begin
      next_state   = state;
      start_accept = 1'b0;
      xfer         = 1'b0;
      data_ready   = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               start_accept = 1'b1;
               next_state   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            data_ready = 1'b1;
            busy       = 1'b1;
            if (data_valid) begin
               xfer = 1'b1;
               if (last) begin
                  next_state = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               start_accept = 1'b1;
               next_state   = ST_LOAD;
            end else begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Operand registers: cleared/latched on an accepted start, filled per transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         matriz_A        <= '0;
         num_inteiro     <= '0;
         matrix_size_out <= '0;
         matriz_valid    <= 1'b0;
      end else if (start_accept) begin
         matriz_A        <= '0;
         num_inteiro     <= num_inteiro_in;
         matrix_size_out <= matrix_size;
         matriz_valid    <= 1'b0;
      end else if (xfer) begin
         matriz_A[int'(index)*ELEM_W +: ELEM_W] <= data_in;
         if (last) begin
            matriz_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_carregador_matriz.sv
// Self-checking bench for carregador_matriz using an element scoreboard.
module tb_carregador_matriz;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   matrix_size;
   logic [7:0]   num_inteiro_in;
   logic [7:0]   data_in;
   logic         data_valid;
   logic         data_ready;
   logic [199:0] matriz_A;
   logic [7:0]   num_inteiro;
   logic [1:0]   matrix_size_out;
   logic         busy;
   logic         matriz_valid;
   logic         done;

   typedef struct {
      int         slot;
      logic [7:0] val;
   } sb_t;

   sb_t          sb[$];
   int           total = 0;
   int           bad = 0;
   int           done_cnt = 0;
   logic [7:0]   elems [25];
   logic [199:0] exp_vec;
   sb_t          e;

   carregador_matriz dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .matrix_size     (matrix_size),
      .num_inteiro_in  (num_inteiro_in),
      .data_in         (data_in),
      .data_valid      (data_valid),
      .data_ready      (data_ready),
      .matriz_A        (matriz_A),
      .num_inteiro     (num_inteiro),
      .matrix_size_out (matrix_size_out),
      .busy            (busy),
      .matriz_valid    (matriz_valid),
      .done            (done)
   );

   always #5 clk = ~clk;

   // done is stable mid-cycle; count the cycles it was high
   always @(posedge clk) if (done === 1'b1) done_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Slot of the k-th streamed element in an NxN matrix
   function automatic int slot_of(input int k, input int n);
`ifdef CARREGADOR_COL_MAJOR_EN
      return (k % n) * n + (k / n);
`else
      return k;
`endif
   endfunction

   // Drive one load; pushes expected slot contents for every accepted element.
   // Returns at the falling edge that follows the final accepting edge.
   task automatic do_load(input logic [1:0] sz, input logic [7:0] sc, input bit gap,
                          input bit mid_start, input bit skip_start, input int max_x,
                          output int xfers, output int lcyc, output bit timed_out);
      int n, act, cyc;
      n = int'(sz) + 2;
      act = n * n;
      xfers = 0;
      lcyc = 0;
      cyc = 0;
      timed_out = 1'b0;
      if (!skip_start) begin
         start = 1'b1;
         matrix_size = sz;
         num_inteiro_in = sc;
         data_valid = 1'b0;
         @(negedge clk);
         start = 1'b0;
      end
      while (xfers < act && xfers < max_x && cyc < 300) begin
         if (busy === 1'b1) lcyc++;
         data_valid = gap ? (cyc % 2 == 0) : 1'b1;
         data_in = elems[xfers];
         if (mid_start) begin
            start = (cyc == 3);
            if (cyc == 3) begin
               matrix_size = 2'b11;
               num_inteiro_in = ~sc;
            end
         end
         if (data_valid && data_ready === 1'b1) begin
            sb.push_back('{slot_of(xfers, n), elems[xfers]});
            xfers++;
         end
         @(negedge clk);
         cyc++;
      end
      data_valid = 1'b0;
      if (mid_start) start = 1'b0;
      if (cyc >= 300) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      matrix_size = 2'b00;
      num_inteiro_in = 8'h00;
      data_in = 8'h00;
      data_valid = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (matriz_A !== 200'd0) begin bad++; $display("FAIL reset_matriz got=%h exp=0", matriz_A); end
      total++;
      if ({num_inteiro, matrix_size_out} !== 10'd0) begin
         bad++; $display("FAIL reset_regs got=%h exp=0", {num_inteiro, matrix_size_out});
      end
      total++;
      if ({data_ready, busy, matriz_valid, done} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags got=%b exp=0000", {data_ready, busy, matriz_valid, done});
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_2x2();
      int x, l, d0;
      bit to;
      elems[0] = 8'd1; elems[1] = 8'hFE; elems[2] = 8'd5; elems[3] = 8'd127;
      d0 = done_cnt;
      do_load(2'b00, 8'd3, 1'b0, 1'b0, 1'b0, 25, x, l, to);
      total++;
      if (to) begin bad++; $display("FAIL 2x2_timeout got=%0d exp<300", l); end
      total++;
      if ({done, matriz_valid} !== 2'b11) begin bad++; $display("FAIL 2x2_done got=%b exp=11", {done, matriz_valid}); end
      exp_vec = '0;
      while (sb.size() > 0) begin e = sb.pop_front(); exp_vec[e.slot*8 +: 8] = e.val; end
      total++;
      if (matriz_A !== exp_vec) begin bad++; $display("FAIL 2x2_matriz got=%h exp=%h", matriz_A, exp_vec); end
`ifndef CARREGADOR_COL_MAJOR_EN
      total++;
      if (matriz_A[31:0] !== 32'h7F05FE01) begin bad++; $display("FAIL 2x2_low got=%h exp=7f05fe01", matriz_A[31:0]); end
`endif
      total++;
      if (num_inteiro !== 8'd3) begin bad++; $display("FAIL 2x2_scalar got=%h exp=03", num_inteiro); end
      total++;
      if (matrix_size_out !== 2'b00) begin bad++; $display("FAIL 2x2_size got=%b exp=00", matrix_size_out); end
      @(negedge clk);
      total++;
      if ({done, matriz_valid, busy} !== 3'b010) begin
         bad++; $display("FAIL 2x2_after got=%b exp=010", {done, matriz_valid, busy});
      end
      total++;
      if (done_cnt - d0 !== 1) begin bad++; $display("FAIL 2x2_pulses got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_5x5_gaps();
      int x, l, d0;
      bit to;
      for (int i = 0; i < 25; i++) elems[i] = 8'(i);
      d0 = done_cnt;
      do_load(2'b11, 8'h81, 1'b1, 1'b0, 1'b0, 25, x, l, to);
      total++;
      if (x !== 25 || to) begin bad++; $display("FAIL 5x5_xfers got=%0d exp=25", x); end
      total++;
      if (l !== 49) begin bad++; $display("FAIL 5x5_load_cycles got=%0d exp=49", l); end
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL 5x5_done got=%b exp=1", done); end
      exp_vec = '0;
      while (sb.size() > 0) begin e = sb.pop_front(); exp_vec[e.slot*8 +: 8] = e.val; end
      total++;
      if (matriz_A !== exp_vec) begin bad++; $display("FAIL 5x5_matriz got=%h exp=%h", matriz_A, exp_vec); end
      repeat (3) @(negedge clk);
      total++;
      if (done_cnt - d0 !== 1) begin bad++; $display("FAIL 5x5_pulses got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_start_mid_load();
      int x, l;
      bit to;
      for (int i = 0; i < 9; i++) elems[i] = 8'(8'h10 + i);
      do_load(2'b01, 8'hF0, 1'b0, 1'b1, 1'b0, 25, x, l, to);
      total++;
      if (x !== 9 || l !== 9 || to) begin bad++; $display("FAIL mid_start_count got=%0d/%0d exp=9/9", x, l); end
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL mid_start_done got=%b exp=1", done); end
      total++;
      if ({matrix_size_out, num_inteiro} !== {2'b01, 8'hF0}) begin
         bad++; $display("FAIL mid_start_latch got=%b/%h exp=01/f0", matrix_size_out, num_inteiro);
      end
      exp_vec = '0;
      while (sb.size() > 0) begin e = sb.pop_front(); exp_vec[e.slot*8 +: 8] = e.val; end
      total++;
      if (matriz_A !== exp_vec) begin bad++; $display("FAIL mid_start_matriz got=%h exp=%h", matriz_A, exp_vec); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_load();
      int x, l, d0;
      bit to;
      for (int i = 0; i < 16; i++) elems[i] = 8'(8'h20 + i);
      d0 = done_cnt;
      do_load(2'b10, 8'd9, 1'b0, 1'b0, 1'b0, 5, x, l, to);
      total++;
      if (x !== 5 || busy !== 1'b1) begin bad++; $display("FAIL abort_setup got=%0d/%b exp=5/1", x, busy); end
      sb.delete();
      #2 reset = 1'b1;
      #1;
      total++;
      if (matriz_A !== 200'd0 || {num_inteiro, matrix_size_out} !== 10'd0) begin
         bad++; $display("FAIL abort_regs got=%h/%h exp=0", matriz_A, {num_inteiro, matrix_size_out});
      end
      total++;
      if ({data_ready, busy, matriz_valid, done} !== 4'b0000) begin
         bad++; $display("FAIL abort_flags got=%b exp=0000", {data_ready, busy, matriz_valid, done});
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      elems[0] = 8'h11; elems[1] = 8'h22; elems[2] = 8'h33; elems[3] = 8'h44;
      do_load(2'b00, 8'h6A, 1'b0, 1'b0, 1'b0, 25, x, l, to);
      total++;
      if (done !== 1'b1 || to) begin bad++; $display("FAIL abort_reload_done got=%b exp=1", done); end
      exp_vec = '0;
      while (sb.size() > 0) begin e = sb.pop_front(); exp_vec[e.slot*8 +: 8] = e.val; end
      total++;
      if (matriz_A !== exp_vec) begin bad++; $display("FAIL abort_reload_matriz got=%h exp=%h", matriz_A, exp_vec); end
      total++;
      if (num_inteiro !== 8'h6A || matrix_size_out !== 2'b00) begin
         bad++; $display("FAIL abort_reload_latch got=%h/%b exp=6a/00", num_inteiro, matrix_size_out);
      end
      repeat (2) @(negedge clk);
      total++;
      if (done_cnt - d0 !== 1) begin bad++; $display("FAIL abort_pulses got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_back_to_back();
      int x, l, d0;
      bit to;
      elems[0] = 8'hA1; elems[1] = 8'hA2; elems[2] = 8'hA3; elems[3] = 8'hA4;
      d0 = done_cnt;
      do_load(2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 25, x, l, to);
      total++;
      if (done !== 1'b1 || to) begin bad++; $display("FAIL b2b_first_done got=%b exp=1", done); end
      exp_vec = '0;
      while (sb.size() > 0) begin e = sb.pop_front(); exp_vec[e.slot*8 +: 8] = e.val; end
      total++;
      if (matriz_A !== exp_vec) begin bad++; $display("FAIL b2b_first_matriz got=%h exp=%h", matriz_A, exp_vec); end
      // start held through DONE and the whole second load
      start = 1'b1;
      matrix_size = 2'b01;
      num_inteiro_in = 8'h21;
      for (int i = 0; i < 9; i++) elems[i] = 8'(8'hC0 + 3 * i);
      @(negedge clk);
      total++;
      if ({busy, matriz_valid, done} !== 3'b100) begin
         bad++; $display("FAIL b2b_restart got=%b exp=100", {busy, matriz_valid, done});
      end
      total++;
      if (matriz_A !== 200'd0 || matrix_size_out !== 2'b01) begin
         bad++; $display("FAIL b2b_relatch got=%h/%b exp=0/01", matriz_A, matrix_size_out);
      end
      do_load(2'b01, 8'h21, 1'b0, 1'b0, 1'b1, 25, x, l, to);
      start = 1'b0;
      total++;
      if (x !== 9 || to || done !== 1'b1) begin bad++; $display("FAIL b2b_second got=%0d/%b exp=9/1", x, done); end
      exp_vec = '0;
      while (sb.size() > 0) begin e = sb.pop_front(); exp_vec[e.slot*8 +: 8] = e.val; end
      total++;
      if (matriz_A !== exp_vec || num_inteiro !== 8'h21) begin
         bad++; $display("FAIL b2b_second_matriz got=%h exp=%h", matriz_A, exp_vec);
      end
      repeat (2) @(negedge clk);
      total++;
      if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", done_cnt - d0); end
   endtask

`ifdef CARREGADOR_COL_MAJOR_EN
   task automatic test_col_major();
      int x, l;
      bit to;
      for (int i = 0; i < 9; i++) elems[i] = 8'(i + 1);
      do_load(2'b01, 8'd2, 1'b0, 1'b0, 1'b0, 25, x, l, to);
      total++;
      if (matriz_A[71:0] !== 72'h090603080502070401 || matriz_A[199:72] !== 128'd0) begin
         bad++; $display("FAIL col_major_layout got=%h exp=090603080502070401", matriz_A);
      end
      exp_vec = '0;
      while (sb.size() > 0) begin e = sb.pop_front(); exp_vec[e.slot*8 +: 8] = e.val; end
      total++;
      if (matriz_A !== exp_vec || done !== 1'b1) begin
         bad++; $display("FAIL col_major_matriz got=%h exp=%h", matriz_A, exp_vec);
      end
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_2x2();
      test_5x5_gaps();
      test_start_mid_load();
      test_reset_mid_load();
      test_back_to_back();
`ifdef CARREGADOR_COL_MAJOR_EN
      test_col_major();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
